// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_if
// Purpose  : Sample request/response handshake between a sample producer and
//            the I2S transmitter.
// Revision : 1.0
// ============================================================================
interface i2s_tx_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_req;

  // master = sample producer, slave = transmitter
  modport master (output sample_in, output sample_valid, input sample_req);
  modport slave  (input sample_in, input sample_valid, output sample_req);

endinterface
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Purpose  : Mono-to-stereo I2S transmitter; requests one sample per frame and
//            serializes it MSB first on both channel slots.
// Revision : 1.0
// ============================================================================
module i2s_tx #(
  parameter int WIDTH     = 16,
  parameter int BCLK_HALF = 32
) (
  input  logic    clk,
  input  logic    reset_n,
  i2s_tx_if.slave smp,
  output logic    bclk,
  output logic    lrclk,
  output logic    sdata,
  output logic    underrun
);

  localparam int c_slots = 2 * WIDTH;
  localparam int c_div_w = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int c_bit_w = $clog2(c_slots);

  localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(BCLK_HALF - 1);
  localparam logic [c_bit_w-1:0] c_slot_last = c_bit_w'(c_slots - 1);
  localparam logic [c_bit_w-1:0] c_slot_load = c_bit_w'(1);
  localparam logic [c_bit_w-1:0] c_slot_half = c_bit_w'(WIDTH);

  logic [c_div_w-1:0] div_q, div_d;
  logic [c_bit_w-1:0] bit_q, bit_d;
  logic [c_slots-1:0] sh_q, sh_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               fresh_q, fresh_d;
  logic               bclk_q, bclk_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               req_q, req_d;
  logic               urun_q, urun_d;

  logic               w_tick;
  logic               w_fall;
  logic [c_bit_w-1:0] w_slot_nxt;
  logic [WIDTH-1:0]   w_sample;

  always_comb begin
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    hold_d     = hold_q;
    fresh_d    = fresh_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    urun_d     = urun_q;
    req_d      = 1'b0;

    w_tick     = (div_q == c_div_last);
    w_fall     = w_tick & bclk_q;
    w_slot_nxt = (bit_q == c_slot_last) ? '0 : bit_q + c_bit_w'(1);
    w_sample   = smp.sample_valid ? smp.sample_in : hold_q;

    div_d      = w_tick ? '0 : div_q + c_div_w'(1);
    bclk_d     = bclk_q ^ w_tick;

    if (smp.sample_valid) begin
      hold_d  = smp.sample_in;
      fresh_d = 1'b1;
    end

    if (w_fall) begin
      bit_d   = w_slot_nxt;
      lrclk_d = (w_slot_nxt >= c_slot_half);
      req_d   = (w_slot_nxt == '0);
      // Slot 1 carries the left MSB, one BCLK after the LRCLK edge.
      if (w_slot_nxt == c_slot_load) begin
        fresh_d = 1'b0;
        if (fresh_q || smp.sample_valid) begin
          sh_d = {w_sample, w_sample};
        end else begin
          sh_d   = '0;
          urun_d = 1'b1;
        end
      end else begin
        sh_d = {sh_q[c_slots-2:0], 1'b0};
      end
      sdata_d = sh_d[c_slots-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      bit_q   <= c_slot_last;
      sh_q    <= '0;
      hold_q  <= '0;
      fresh_q <= 1'b0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      req_q   <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      fresh_q <= fresh_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      req_q   <= req_d;
      urun_q  <= urun_d;
    end
  end

  assign smp.sample_req = req_q;
  assign bclk           = bclk_q;
  assign lrclk          = lrclk_q;
  assign sdata          = sdata_q;
  assign underrun       = urun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Purpose  : Self-checking bench for i2s_tx at BCLK_HALF=32 and BCLK_HALF=1
//            against a frame-level timing model.
// Revision : 1.0
// ============================================================================
module tb_i2s_tx;

  localparam int W = 16;

  // k1/k2: cycle offsets after the request edge at which sample_valid is seen
  typedef struct {
    int          k1;
    logic [15:0] v1;
    int          k2;
    logic [15:0] v2;
    logic [15:0] ew;
    bit          eu;
    bit          chk;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn;
  logic [1:0]  drv_v;
  logic [15:0] drv_w [2];
  logic [1:0]  o_bclk, o_lr, o_sd, o_ur;
  logic [1:0]  obs_req;

  i2s_tx_if #(.WIDTH(W)) if0 ();
  i2s_tx_if #(.WIDTH(W)) if1 ();

  assign if0.sample_valid = drv_v[0];
  assign if0.sample_in    = drv_w[0];
  assign if1.sample_valid = drv_v[1];
  assign if1.sample_in    = drv_w[1];
  assign obs_req          = {if1.sample_req, if0.sample_req};

  i2s_tx #(.WIDTH(W), .BCLK_HALF(32)) dut0 (
    .clk(clk), .reset_n(rstn[0]), .smp(if0),
    .bclk(o_bclk[0]), .lrclk(o_lr[0]), .sdata(o_sd[0]), .underrun(o_ur[0])
  );

  i2s_tx #(.WIDTH(W), .BCLK_HALF(1)) dut1 (
    .clk(clk), .reset_n(rstn[1]), .smp(if1),
    .bclk(o_bclk[1]), .lrclk(o_lr[1]), .sdata(o_sd[1]), .underrun(o_ur[1])
  );

  int          errors = 0;
  int          checks = 0;
  int          n     [2];
  int          nload [2];
  bit          pend_v[2];
  logic [15:0] pend_w[2];
  bit          urun  [2];
  logic [15:0] mword [2][1024];
  frame_t      fent  [2][1024];
  frame_t      cur   [2];
  int          base  [2];
  int          sp    [2];
  logic [31:0] cap   [2];
  bit          req_seen[2];
  int          last_req[2];
  frame_t      tab0  [7];
  frame_t      tab1  [4];

  function automatic int bhf(int d);
    return (d == 0) ? 32 : 1;
  endfunction

  function automatic int slot_of(int d);
    int m;
    m = n[d] / (2 * bhf(d));
    return (m == 0) ? -1 : (m - 1) % 32;
  endfunction

  task automatic model_reset(int d);
    n[d]        = 0;
    nload[d]    = 0;
    pend_v[d]   = 1'b0;
    urun[d]     = 1'b0;
    req_seen[d] = 1'b0;
    base[d]     = -1000000;
    cur[d].k1   = 0;
    cur[d].k2   = 0;
  endtask

  // Frame f is loaded at the fall tick entering slot 1 of that frame.
  task automatic model_edge(int d);
    int b, ld;
    b = bhf(d);
    n[d]++;
    ld = 2 * b * (32 * nload[d] + 2);
    if (n[d] == ld) begin
      if (drv_v[d])       mword[d][nload[d]] = drv_w[d];
      else if (pend_v[d]) mword[d][nload[d]] = pend_w[d];
      else begin
        mword[d][nload[d]] = 16'h0000;
        urun[d]            = 1'b1;
      end
      pend_v[d] = 1'b0;
      if (nload[d] < 1023) nload[d]++;
    end else if (drv_v[d]) begin
      pend_v[d] = 1'b1;
      pend_w[d] = drv_w[d];
    end
  endtask

  function automatic logic [4:0] expv(int d);
    int b, m, slot, fr;
    logic [15:0] wv;
    logic rq, bc, lr, sd;
    b  = bhf(d);
    m  = n[d] / (2 * b);
    bc = ((n[d] / b) % 2) == 1;
    rq = 1'b0; lr = 1'b1; sd = 1'b0;
    if (m > 0) begin
      slot = (m - 1) % 32;
      lr   = (slot >= 16);
      rq   = (slot == 0) && ((n[d] % (2 * b)) == 0);
      fr   = (slot == 0) ? (m - 1) / 32 - 1 : (m - 1) / 32;
      if (fr >= 0 && fr < 1024) begin
        wv = mword[d][fr];
        sd = (slot == 0) ? wv[0] : wv[(32 - slot) % 16];
      end
    end
    return {rq, bc, lr, sd, urun[d]};
  endfunction

  task automatic chk_vec(int d, logic [4:0] e, string nm);
    logic [4:0] a;
    a = {obs_req[d], o_bclk[d], o_lr[d], o_sd[d], o_ur[d]};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %b expected %b (req,bclk,lrclk,sdata,underrun)",
               nm, d, n[d], a, e);
    end
  endtask

  task automatic chk_req(int d);
    int b;
    b = bhf(d);
    if (obs_req[d]) begin
      checks++;
      if (!req_seen[d]) begin
        if (n[d] != 2 * b) begin
          errors++;
          $display("FAIL first_req dut%0d: got edge %0d expected edge %0d", d, n[d], 2 * b);
        end
      end else if (n[d] - last_req[d] != 64 * b) begin
        errors++;
        $display("FAIL req_period dut%0d: got %0d expected %0d", d, n[d] - last_req[d], 64 * b);
      end
      req_seen[d] = 1'b1;
      last_req[d] = n[d];
    end
  endtask

  task automatic capture(int d);
    int b, m, slot, fr;
    b = bhf(d);
    if (n[d] >= b && (n[d] % (2 * b)) == b) begin
      m = n[d] / (2 * b);
      if (m >= 1) begin
        slot = (m - 1) % 32;
        if (slot != 0) cap[d][32 - slot] = o_sd[d];
        else if (m >= 33) begin
          cap[d][0] = o_sd[d];
          fr = (m - 1) / 32 - 1;
          checks++;
          if (cap[d] !== {mword[d][fr], mword[d][fr]}) begin
            errors++;
            $display("FAIL frame_bits dut%0d frame %0d: got %h expected %h",
                     d, fr, cap[d], {mword[d][fr], mword[d][fr]});
          end
          if (fent[d][fr].chk) begin
            checks += 2;
            if (cap[d] !== {fent[d][fr].ew, fent[d][fr].ew}) begin
              errors++;
              $display("FAIL table_word dut%0d frame %0d: got %h expected %h",
                       d, fr, cap[d], {fent[d][fr].ew, fent[d][fr].ew});
            end
            if (o_ur[d] !== fent[d][fr].eu) begin
              errors++;
              $display("FAIL table_underrun dut%0d frame %0d: got %b expected %b",
                       d, fr, o_ur[d], fent[d][fr].eu);
            end
          end
        end
      end
    end
  endtask

  function automatic frame_t next_entry(int d);
    frame_t e;
    int r, lim;
    lim = 2 * bhf(d) + 1;
    if (d == 0 && sp[0] < 7)      e = tab0[sp[0]];
    else if (d == 1 && sp[1] < 4) e = tab1[sp[1]];
    else begin
      r    = $urandom_range(0, 7);
      e.k1 = (r == 0) ? 0 : $urandom_range(1, lim);
      e.v1 = 16'($urandom);
      e.k2 = (r == 7 && e.k1 < lim) ? $urandom_range(e.k1 + 1, lim) : 0;
      e.v2 = 16'($urandom);
      e.ew = 16'h0000;
      e.eu = 1'b0;
      e.chk = 1'b0;
    end
    sp[d]++;
    return e;
  endfunction

  task automatic plan(int d);
    int b, per, fr, off;
    b   = bhf(d);
    per = 64 * b;
    if (n[d] >= 2 * b && ((n[d] - 2 * b) % per) == 0) begin
      fr      = (n[d] - 2 * b) / per;
      cur[d]  = next_entry(d);
      base[d] = n[d];
      if (fr < 1024) fent[d][fr] = cur[d];
    end
    off      = n[d] + 1 - base[d];
    drv_v[d] = 1'b0;
    drv_w[d] = 16'($urandom);
    if (cur[d].k2 != 0 && off == cur[d].k2) begin
      drv_v[d] = 1'b1;
      drv_w[d] = cur[d].v2;
    end else if (cur[d].k1 != 0 && off == cur[d].k1) begin
      drv_v[d] = 1'b1;
      drv_w[d] = cur[d].v1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 2; d++) if (rstn[d]) model_edge(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rstn[d]) begin
        model_reset(d);
        drv_v[d] = 1'b0;
        chk_vec(d, 5'b00100, "reset_outputs");
      end else begin
        chk_vec(d, expv(d), "outputs");
        chk_req(d);
        capture(d);
        plan(d);
      end
    end
  endtask

  initial begin
    int guard;
    // {k1, v1, k2, v2, expected word, expected underrun after frame, checked}
    tab0[0] = '{1,  16'hA5C3, 0,  16'h0000, 16'hA5C3, 1'b0, 1'b1};
    tab0[1] = '{64, 16'h8001, 0,  16'h0000, 16'h8001, 1'b0, 1'b1};
    tab0[2] = '{65, 16'h8001, 0,  16'h0000, 16'h0000, 1'b1, 1'b1};
    tab0[3] = '{0,  16'h0000, 0,  16'h0000, 16'h8001, 1'b1, 1'b1};
    tab0[4] = '{0,  16'h0000, 0,  16'h0000, 16'h0000, 1'b1, 1'b1};
    tab0[5] = '{1,  16'h7FFF, 0,  16'h0000, 16'h7FFF, 1'b1, 1'b1};
    tab0[6] = '{3,  16'h1111, 40, 16'h2222, 16'h2222, 1'b1, 1'b1};
    tab1[0] = '{1,  16'h1234, 0,  16'h0000, 16'h1234, 1'b0, 1'b1};
    tab1[1] = '{1,  16'hFFFF, 0,  16'h0000, 16'hFFFF, 1'b0, 1'b1};
    tab1[2] = '{1,  16'h0000, 0,  16'h0000, 16'h0000, 1'b0, 1'b1};
    tab1[3] = '{2,  16'h5A5A, 0,  16'h0000, 16'h5A5A, 1'b0, 1'b1};

    sp[0] = 0; sp[1] = 0;
    rstn  = 2'b00;
    drv_v = 2'b00;
    drv_w[0] = 16'h0; drv_w[1] = 16'h0;
    model_reset(0);
    model_reset(1);
    repeat (3) cycle();
    rstn = 2'b11;

    guard = 0;
    while (!(sp[0] >= 8 && slot_of(0) == 9)) begin
      cycle();
      guard++;
      if (guard > 40000) begin
        errors++;
        checks++;
        $display("FAIL slot9_wait: got timeout after %0d cycles expected slot 9", guard);
        break;
      end
    end

    rstn[0]  = 1'b0;
    drv_v[0] = 1'b0;
    model_reset(0);
    #1;
    chk_vec(0, 5'b00100, "midframe_reset");
    repeat (4) cycle();
    rstn[0] = 1'b1;

    repeat (6 * 2048 + 200) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
